// File: rtl/gpio_seg_pkg.sv
// Shared definitions for the GPIO seven-segment path: scan FSM states,
// the all-segments-off pattern and the hex digit encoding table.
package gpio_seg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        ON    = 2'd2
    } scan_state_t;

    // Active-low bus: every segment (and DP) dark.
    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Hex nibble to active-low {DP,G,F,E,D,C,B,A} pattern, DP kept dark.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] hex);
        logic [7:0] seg;
        case (hex)
            4'h0:    seg = 8'hC0;
            4'h1:    seg = 8'hF9;
            4'h2:    seg = 8'hA4;
            4'h3:    seg = 8'hB0;
            4'h4:    seg = 8'h99;
            4'h5:    seg = 8'h92;
            4'h6:    seg = 8'h82;
            4'h7:    seg = 8'hF8;
            4'h8:    seg = 8'h80;
            4'h9:    seg = 8'h90;
            4'hA:    seg = 8'h88;
            4'hB:    seg = 8'h83;
            4'hC:    seg = 8'hC6;
            4'hD:    seg = 8'hA1;
            4'hE:    seg = 8'h86;
            default: seg = 8'h8E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/gpio_scan_timer.sv
// Loadable down-counter timing the BLANK and ON phases of the scan.
// tc is high while the count sits at zero, i.e. on the last cycle of a phase.
module gpio_scan_timer
    import gpio_seg_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         tc
);

    // Count register: clear wins over load, load wins over decrement, hold at zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    // Terminal count flag.
    always_comb begin
        tc = (count == '0);
    end

endmodule

// File: rtl/gpio_seg_scan.sv
// Time-multiplexed seven-segment scan controller: one shared active-low
// segment bus, one-hot active-low digit select, inter-digit blanking and
// 16-level brightness by lighting only the first part of each ON phase.
module gpio_seg_scan
    import gpio_seg_pkg::*;
#(
    parameter int unsigned NDIG      = 8,
    parameter int unsigned SCAN_DIV  = 1000,
    parameter int unsigned BLANK_CYC = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              en,
    input  logic [3:0]        bright,
    input  logic [NDIG*8-1:0] seg_in,
    output logic [7:0]        seg_out,
    output logic [NDIG-1:0]   dig_sel_n,
    output logic              frame_tick,
    output logic              busy
);

    localparam int unsigned DW     = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int unsigned MAXLEN = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int unsigned TW     = $clog2(MAXLEN);
    localparam int unsigned DUTY_W = $clog2(SCAN_DIV) + 5;
    localparam int unsigned CW     = (DUTY_W > TW) ? DUTY_W : TW;

    scan_state_t    state;
    scan_state_t    state_nx;
    logic [DW-1:0]  digit;
    logic           digit_adv;
    logic           wrap;
    logic           snap_en;
    logic [7:0]     snap_seg;
    logic [3:0]     snap_bright;
    logic [7:0]     cur_seg;
    logic [NDIG-1:0] sel_lit;
    logic           tmr_clr;
    logic           tmr_load;
    logic [TW-1:0]  tmr_val;
    logic [TW-1:0]  tmr_count;
    logic           tmr_tc;
    logic [CW-1:0]  duty;
    logic [CW-1:0]  thresh;
    logic           lit;

    gpio_scan_timer #(
        .W (TW)
    ) u_timer (
        .clock    (clock),
        .reset_n  (reset_n),
        .clr      (tmr_clr),
        .load     (tmr_load),
        .load_val (tmr_val),
        .count    (tmr_count),
        .tc       (tmr_tc)
    );

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and phase-timer control; en low drops to IDLE from anywhere.
    always_comb begin
        state_nx  = state;
        tmr_clr   = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        snap_en   = 1'b0;
        digit_adv = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    state_nx = BLANK;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(BLANK_CYC - 1);
                end else begin
                    tmr_clr = 1'b1;
                end
            end
            BLANK: begin
                if (!en) begin
                    state_nx = IDLE;
                    tmr_clr  = 1'b1;
                end else if (tmr_tc) begin
                    state_nx = ON;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(SCAN_DIV - 1);
                    snap_en  = 1'b1;
                end
            end
            ON: begin
                if (!en) begin
                    state_nx = IDLE;
                    tmr_clr  = 1'b1;
                end else if (tmr_tc) begin
                    state_nx  = BLANK;
                    tmr_load  = 1'b1;
                    tmr_val   = TW'(BLANK_CYC - 1);
                    digit_adv = 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                tmr_clr  = 1'b1;
            end
        endcase
    end

    // Wrap from the last digit back to digit 0 marks the frame boundary.
    always_comb begin
        wrap = digit_adv && (digit == DW'(NDIG - 1));
    end

    // Digit index: held at 0 in IDLE so a restart always begins at digit 0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            digit <= '0;
        end else if (state_nx == IDLE) begin
            digit <= '0;
        end else if (digit_adv) begin
            digit <= wrap ? '0 : digit + 1'b1;
        end
    end

    // Select the current digit's pattern and build its one-hot select.
    always_comb begin
        cur_seg = SEG_OFF;
        sel_lit = '1;
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (digit == DW'(i)) begin
                cur_seg    = seg_in[i*8 +: 8];
                sel_lit[i] = 1'b0;
            end
        end
    end

    // Snapshot pattern and brightness at ON entry; later input changes wait for the next digit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            snap_seg    <= SEG_OFF;
            snap_bright <= '0;
        end else if (snap_en) begin
            snap_seg    <= cur_seg;
            snap_bright <= bright;
        end
    end

    // The timer counts down, so ON count c < duty is equivalent to count >= SCAN_DIV - duty.
    always_comb begin
        duty   = ((CW'(snap_bright) + CW'(1)) * CW'(SCAN_DIV)) >> 4;
        thresh = CW'(SCAN_DIV) - duty;
        lit    = en && (state == ON) && (CW'(tmr_count) >= thresh);
    end

    // Registered outputs; gating on en blanks the display in the cycle after en drops.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            seg_out    <= SEG_OFF;
            dig_sel_n  <= '1;
            frame_tick <= 1'b0;
            busy       <= 1'b0;
        end else begin
            seg_out    <= lit ? snap_seg : SEG_OFF;
            dig_sel_n  <= lit ? sel_lit : '1;
            frame_tick <= wrap;
            busy       <= (state_nx != IDLE);
        end
    end

endmodule

// File: tb/tb_gpio_seg_scan.sv
// Scoreboard bench for gpio_seg_scan: per-cycle expected outputs are queued
// as stimulus is applied and compared on the falling clock edge.
module tb_gpio_seg_scan;

    localparam int unsigned NDIG = 8;
    localparam int unsigned S    = 16;
    localparam int unsigned B    = 2;

    logic              clock;
    logic              reset_n;
    logic              en;
    logic [3:0]        bright;
    logic [NDIG*8-1:0] seg_in;
    logic [7:0]        seg_out;
    logic [NDIG-1:0]   dig_sel_n;
    logic              frame_tick;
    logic              busy;

    typedef struct packed {
        logic [7:0] seg;
        logic [7:0] sel;
        logic       ft;
        logic       busy;
    } exp_t;

    exp_t       q[$];
    logic [7:0] pat [NDIG];
    int         checks;
    int         failures;

    gpio_seg_scan #(
        .NDIG      (NDIG),
        .SCAN_DIV  (S),
        .BLANK_CYC (B)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .en         (en),
        .bright     (bright),
        .seg_in     (seg_in),
        .seg_out    (seg_out),
        .dig_sel_n  (dig_sel_n),
        .frame_tick (frame_tick),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] sel_of(input int unsigned d);
        logic [7:0] s;
        s    = 8'hFF;
        s[d] = 1'b0;
        return s;
    endfunction

    function automatic int unsigned duty_of(input int unsigned b);
        return ((b + 1) * S) / 16;
    endfunction

    task automatic push_off(input int unsigned n, input logic bsy);
        exp_t e;
        for (int unsigned i = 0; i < n; i++) begin
            e.seg  = 8'hFF;
            e.sel  = 8'hFF;
            e.ft   = 1'b0;
            e.busy = bsy;
            q.push_back(e);
        end
    endtask

    task automatic push_on(input int unsigned d, input logic [7:0] seg, input int unsigned duty,
                           input int unsigned c0, input int unsigned c1);
        exp_t e;
        for (int unsigned c = c0; c <= c1; c++) begin
            e.seg  = (c < duty) ? seg : 8'hFF;
            e.sel  = (c < duty) ? sel_of(d) : 8'hFF;
            e.ft   = (c == S - 1) && (d == NDIG - 1);
            e.busy = 1'b1;
            q.push_back(e);
        end
    endtask

    task automatic push_digit(input int unsigned d, input logic [7:0] seg, input int unsigned duty);
        push_off(B, 1'b1);
        push_on(d, seg, duty, 0, S - 1);
    endtask

    task automatic drain();
        exp_t e;
        while (q.size() > 0) begin
            @(negedge clock);
            e = q.pop_front();
            check_eq("seg_out", 32'(seg_out), 32'(e.seg));
            check_eq("dig_sel_n", 32'(dig_sel_n), 32'(e.sel));
            check_eq("frame_tick", 32'(frame_tick), 32'(e.ft));
            check_eq("busy", 32'(busy), 32'(e.busy));
        end
    endtask

    task automatic check_off(input string tag);
        check_eq({tag, "_seg"}, 32'(seg_out), 32'h0000_00FF);
        check_eq({tag, "_sel"}, 32'(dig_sel_n), 32'h0000_00FF);
        check_eq({tag, "_ft"}, 32'(frame_tick), 32'h0);
        check_eq({tag, "_busy"}, 32'(busy), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b1;
        en       = 1'b1;
        bright   = 4'd15;
        for (int unsigned d = 0; d < NDIG; d++) begin
            pat[d]          = 8'hF0 | 8'(d);
            seg_in[d*8 +: 8] = pat[d];
        end
        #1 reset_n = 1'b0;

        // Reset held with en high: outputs off, not busy.
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check_off("reset");
        end
        reset_n = 1'b1;

        // Full brightness frame, including the leading IDLE->BLANK cycle.
        push_off(1, 1'b1);
        for (int unsigned d = 0; d < NDIG; d++) push_digit(d, pat[d], duty_of(15));
        drain();

        // Brightness 3 takes effect from digit 0's ON entry.
        bright = 4'd3;
        for (int unsigned d = 0; d < NDIG; d++) push_digit(d, pat[d], duty_of(3));
        drain();

        // Pattern change mid-ON of digit 2 is ignored until the next frame.
        push_digit(0, pat[0], duty_of(3));
        push_digit(1, pat[1], duty_of(3));
        push_off(B, 1'b1);
        push_on(2, 8'hF2, duty_of(3), 0, 4);
        drain();
        seg_in[23:16] = 8'h00;
        pat[2]        = 8'h00;
        push_on(2, 8'hF2, duty_of(3), 5, S - 1);
        for (int unsigned d = 3; d < NDIG; d++) push_digit(d, pat[d], duty_of(3));
        drain();

        // Next frame shows the new pattern; en drops at ON cycle 7 of digit 5.
        for (int unsigned d = 0; d < 5; d++) push_digit(d, pat[d], duty_of(3));
        push_off(B, 1'b1);
        push_on(5, pat[5], duty_of(3), 0, 6);
        drain();
        en = 1'b0;
        push_off(3, 1'b0);
        drain();

        // Re-enable restarts at digit 0 with a full blank.
        en = 1'b1;
        push_off(1, 1'b1);
        push_digit(0, pat[0], duty_of(3));
        push_digit(1, pat[1], duty_of(3));
        push_off(B, 1'b1);
        push_on(2, pat[2], duty_of(3), 0, 1);
        drain();

        // Asynchronous reset while digit 2 is lit.
        #2 reset_n = 1'b0;
        #1 check_off("async_reset");
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            check_off("reset_hold");
        end
        reset_n = 1'b1;
        push_off(1, 1'b1);
        push_digit(0, pat[0], duty_of(3));
        push_digit(1, pat[1], duty_of(3));
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
